hmi_pkg_rx: RTL and testbench

- Upstream stage of the HMI channel-indicator path: parses a UART byte stream into framed 16-bit word packets on the pkg_data/pkg_vld/pkg_frm bus used by the LED/channel consumer.
- Buffers a whole packet and verifies the checksum before releasing it. Corrupt, truncated or stalled frames never reach the consumer.
- First word is presented on the same cycle pkg_frm rises, so the consumer can latch the channel word from its idle state.

---
 rtl/hmi_pkg_rx_pkg.sv | 31 +++
 rtl/hmi_pkg_buf.sv | 33 +++
 rtl/hmi_pkg_rx.sv | 210 +++++++++++++++++++++
 tb/tb_hmi_pkg_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hmi_pkg_rx_pkg.sv
// hmi_pkg_defs: shared definitions for the HMI packet receiver.
//   - hmi_state_e : receiver FSM state encoding (3 bits)
//   - *_DEF       : default frame parameters (header bytes, capacity, timeout)
//   - idx_w()     : index width helper that never returns zero
package hmi_pkg_defs;

    typedef enum logic [2:0] {
        S_HUNT1 = 3'd0,
        S_HUNT2 = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_CHK   = 3'd4,
        S_PLAY  = 3'd5,
        S_END   = 3'd6
    } hmi_state_e;

    localparam int           MAX_WORDS_DEF  = 16;
    localparam int           TIMEOUT_US_DEF = 2000;
    localparam logic [7:0]   HDR0_DEF       = 8'hAA;
    localparam logic [7:0]   HDR1_DEF       = 8'h55;

    // Width of an index addressing n entries; at least 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WORD_IDX_W_DEF = idx_w(MAX_WORDS_DEF);
    localparam int LEN_W_DEF      = $clog2(MAX_WORDS_DEF + 1);
    localparam int TMO_W_DEF      = $clog2(TIMEOUT_US_DEF + 1);

endpackage

// File: rtl/hmi_pkg_buf.sv
// hmi_pkg_buf: DEPTH x 16 register file holding one packet payload.
// Ports:
//   clk    - clock
//   we     - synchronous write enable
//   waddr  - write word address
//   wdata  - write word
//   raddr  - combinational read address
//   rdata  - combinational read data
// Contents are not reset; the receiver only reads words it has written
// for the current frame.
module hmi_pkg_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hmi_pkg_rx.sv
// hmi_pkg_rx: parses a UART byte stream into checksummed 16-bit word packets.
// Frame: HDR0, HDR1, LEN, 2*LEN payload bytes (MSB first per word), CHK where
// CHK = (LEN + sum of payload bytes) mod 256. The whole payload is buffered
// and only replayed once CHK matches, so bad frames never reach the consumer.
// Ports:
//   clk_sys   - system clock
//   rst_n     - synchronous active-low reset
//   pluse_us  - 1 us tick used for the inter-byte timeout
//   rx_data   - received byte, valid when rx_vld=1
//   rx_vld    - byte strobe
//   pkg_data  - packet word (0 when pkg_vld=0)
//   pkg_vld   - word strobe, high for LEN consecutive cycles
//   pkg_frm   - packet envelope, high for LEN+1 cycles
//   err_cnt   - saturating count of dropped frames/bytes
module hmi_pkg_rx
    import hmi_pkg_defs::*;
#(
    parameter int         MAX_WORDS  = MAX_WORDS_DEF,
    parameter int         TIMEOUT_US = TIMEOUT_US_DEF,
    parameter logic [7:0] HDR0       = HDR0_DEF,
    parameter logic [7:0] HDR1       = HDR1_DEF
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pluse_us,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic [15:0] pkg_data,
    output logic        pkg_vld,
    output logic        pkg_frm,
    output logic [7:0]  err_cnt
);

    localparam int IW = idx_w(MAX_WORDS);          // word index width
    localparam int LW = $clog2(MAX_WORDS + 1);     // holds 0..MAX_WORDS
    localparam int TW = $clog2(TIMEOUT_US + 1);    // gap counter width
    localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT_US - 1);

    hmi_state_e    state_q,    state_d;
    logic [LW-1:0] len_q,      len_d;
    logic [7:0]    sum_q,      sum_d;
    logic [LW:0]   byte_idx_q, byte_idx_d;   // 0 .. 2*MAX_WORDS-1
    logic [7:0]    hi_q,       hi_d;
    logic [IW-1:0] rd_idx_q,   rd_idx_d;
    logic [TW-1:0] gap_q,      gap_d;
    logic [15:0]   pkg_data_q, pkg_data_d;
    logic          pkg_vld_q,  pkg_vld_d;
    logic          pkg_frm_q,  pkg_frm_d;
    logic [7:0]    err_q,      err_d;

    logic          err_inc;
    logic          buf_we;
    logic [15:0]   buf_rdata;
    logic [LW:0]   last_byte_idx;
    logic          len_ok;

    assign last_byte_idx = {len_q, 1'b0} - (LW+1)'(1);
    assign len_ok        = (int'(rx_data) >= 1) && (int'(rx_data) <= MAX_WORDS);

    hmi_pkg_buf #(
        .DEPTH (MAX_WORDS),
        .AW    (IW)
    ) u_buf (
        .clk   (clk_sys),
        .we    (buf_we),
        .waddr (byte_idx_q[IW:1]),
        .wdata ({hi_q, rx_data}),
        .raddr (rd_idx_q),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        byte_idx_d = byte_idx_q;
        hi_d       = hi_q;
        rd_idx_d   = rd_idx_q;
        gap_d      = gap_q;
        err_inc    = 1'b0;
        buf_we     = 1'b0;
        pkg_data_d = 16'h0;
        pkg_vld_d  = 1'b0;
        pkg_frm_d  = 1'b0;

        case (state_q)
            S_HUNT1: begin
                gap_d = '0;
                if (rx_vld && rx_data == HDR0) begin
                    state_d = S_HUNT2;
                end
            end

            S_HUNT2, S_LEN, S_DATA, S_CHK: begin
                // A byte arriving on the timeout tick wins over the abort.
                if (rx_vld) begin
                    gap_d = '0;
                    case (state_q)
                        S_HUNT2: begin
                            if (rx_data == HDR1) begin
                                state_d = S_LEN;
                            end else if (rx_data != HDR0) begin
                                state_d = S_HUNT1;
                            end
                        end
                        S_LEN: begin
                            if (len_ok) begin
                                state_d    = S_DATA;
                                len_d      = LW'(rx_data);
                                sum_d      = rx_data;
                                byte_idx_d = '0;
                            end else begin
                                err_inc = 1'b1;
                                state_d = S_HUNT1;
                            end
                        end
                        S_DATA: begin
                            sum_d      = sum_q + rx_data;
                            byte_idx_d = byte_idx_q + (LW+1)'(1);
                            if (byte_idx_q[0]) begin
                                buf_we = 1'b1;
                            end else begin
                                hi_d = rx_data;
                            end
                            if (byte_idx_q == last_byte_idx) begin
                                state_d = S_CHK;
                            end
                        end
                        S_CHK: begin
                            if (rx_data == sum_q) begin
                                state_d  = S_PLAY;
                                rd_idx_d = '0;
                            end else begin
                                err_inc = 1'b1;
                                state_d = S_HUNT1;
                            end
                        end
                        default: state_d = S_HUNT1;
                    endcase
                end else if (pluse_us) begin
                    if (gap_q == GAP_LAST) begin
                        err_inc = 1'b1;
                        state_d = S_HUNT1;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + TW'(1);
                    end
                end
            end

            S_PLAY: begin
                gap_d      = '0;
                pkg_frm_d  = 1'b1;
                pkg_vld_d  = 1'b1;
                pkg_data_d = buf_rdata;
                rd_idx_d   = rd_idx_q + IW'(1);
                if (LW'(rd_idx_q) == len_q - LW'(1)) begin
                    state_d = S_END;
                end
                // Bytes during replay are dropped without disturbing it.
                err_inc = rx_vld;
            end

            S_END: begin
                gap_d     = '0;
                pkg_frm_d = 1'b1;
                state_d   = S_HUNT1;
                err_inc   = rx_vld;
            end

            default: state_d = S_HUNT1;
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= S_HUNT1;
            len_q      <= '0;
            sum_q      <= '0;
            byte_idx_q <= '0;
            hi_q       <= '0;
            rd_idx_q   <= '0;
            gap_q      <= '0;
            pkg_data_q <= '0;
            pkg_vld_q  <= 1'b0;
            pkg_frm_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            byte_idx_q <= byte_idx_d;
            hi_q       <= hi_d;
            rd_idx_q   <= rd_idx_d;
            gap_q      <= gap_d;
            pkg_data_q <= pkg_data_d;
            pkg_vld_q  <= pkg_vld_d;
            pkg_frm_q  <= pkg_frm_d;
            err_q      <= err_d;
        end
    end

    assign pkg_data = pkg_data_q;
    assign pkg_vld  = pkg_vld_q;
    assign pkg_frm  = pkg_frm_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_hmi_pkg_rx.sv
// Directed bench for hmi_pkg_rx. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
module tb_hmi_pkg_rx;

    logic        clk_sys;
    logic        rst_n;
    logic        pluse_us;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [15:0] pkg_data;
    logic        pkg_vld;
    logic        pkg_frm;
    logic [7:0]  err_cnt;

    int n_checks;
    int n_fails;

    logic [15:0] payload [16];

    hmi_pkg_rx dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .pluse_us (pluse_us),
        .rx_data  (rx_data),
        .rx_vld   (rx_vld),
        .pkg_data (pkg_data),
        .pkg_vld  (pkg_vld),
        .pkg_frm  (pkg_frm),
        .err_cnt  (err_cnt)
    );

    // clock
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one byte for exactly one active edge; entered and left at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_vld  = 1'b1;
        rx_data = b;
        @(negedge clk_sys);
        rx_vld  = 1'b0;
        rx_data = 8'h00;
    endtask

    // Full frame from payload[0..n-1]; bad_chk corrupts the checksum by +1.
    task automatic send_frame(input int n, input bit bad_chk);
        logic [7:0] sum;
        sum = 8'(n);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(payload[i][15:8]);
            send_byte(payload[i][7:0]);
            sum = sum + payload[i][15:8] + payload[i][7:0];
        end
        send_byte(bad_chk ? sum + 8'd1 : sum);
    endtask

    // Checks the replay right after the CHK byte: envelope not yet up, then n words,
    // one trailing envelope cycle, then idle. inject_at>=0 drives a stray byte during replay.
    task automatic expect_packet(input string tag, input int n, input int inject_at);
        check({tag, " frm before replay"}, 32'(pkg_frm), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i == inject_at) begin
                rx_vld  = 1'b1;
                rx_data = 8'hAA;
            end else begin
                rx_vld  = 1'b0;
                rx_data = 8'h00;
            end
            @(negedge clk_sys);
            check({tag, " frm"},  32'(pkg_frm),  32'd1);
            check({tag, " vld"},  32'(pkg_vld),  32'd1);
            check({tag, " data"}, 32'(pkg_data), 32'(payload[i]));
        end
        rx_vld  = 1'b0;
        rx_data = 8'h00;
        @(negedge clk_sys);
        check({tag, " end frm"},  32'(pkg_frm),  32'd1);
        check({tag, " end vld"},  32'(pkg_vld),  32'd0);
        check({tag, " end data"}, 32'(pkg_data), 32'd0);
        @(negedge clk_sys);
        check({tag, " after frm"}, 32'(pkg_frm), 32'd0);
        check({tag, " after vld"}, 32'(pkg_vld), 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_sys);
            check({tag, " quiet frm"},  32'(pkg_frm),  32'd0);
            check({tag, " quiet vld"},  32'(pkg_vld),  32'd0);
            check({tag, " quiet data"}, 32'(pkg_data), 32'd0);
        end
    endtask

    // Holds pluse_us high for n consecutive cycles.
    task automatic ticks(input int n);
        pluse_us = 1'b1;
        repeat (n) @(negedge clk_sys);
        pluse_us = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        pluse_us = 1'b0;
        rx_data  = 8'h00;
        rx_vld   = 1'b0;
        for (int i = 0; i < 16; i++) payload[i] = 16'h0;

        // reset
        repeat (3) @(negedge clk_sys);
        check("reset frm",  32'(pkg_frm),  32'd0);
        check("reset vld",  32'(pkg_vld),  32'd0);
        check("reset data", 32'(pkg_data), 32'd0);
        check("reset err",  32'(err_cnt),  32'd0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // valid frame AA 55 02 00 03 12 34 4B
        payload[0] = 16'h0003;
        payload[1] = 16'h1234;
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h4B);
        expect_packet("frameA", 2, -1);
        check("frameA err", 32'(err_cnt), 32'd0);

        // same frame with bad checksum 4C
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h4C);
        expect_quiet("badchk", 6);
        check("badchk err", 32'(err_cnt), 32'd1);

        payload[0] = 16'hBEEF;
        payload[1] = 16'h0001;
        send_frame(2, 1'b0);
        expect_packet("after badchk", 2, -1);
        check("after badchk err", 32'(err_cnt), 32'd1);

        // illegal lengths
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        expect_quiet("len00", 2);
        check("len00 err", 32'(err_cnt), 32'd2);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h11);
        expect_quiet("len17", 2);
        check("len17 err", 32'(err_cnt), 32'd3);

        // junk then resync: 11 AA AA 55 01 00 05 06
        payload[0] = 16'h0005;
        send_byte(8'h11); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h06);
        expect_packet("resync", 1, -1);
        check("resync err", 32'(err_cnt), 32'd3);

        // gap of TIMEOUT_US-1 ticks survives; byte on the timeout tick wins
        payload[0] = 16'h1122;
        payload[1] = 16'h3344;
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        ticks(1999);
        pluse_us = 1'b1;
        send_byte(8'h33);
        pluse_us = 1'b0;
        send_byte(8'h44); send_byte(8'hAC);
        expect_packet("gap1999", 2, -1);
        check("gap1999 err", 32'(err_cnt), 32'd3);

        // full timeout after 3 payload bytes
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        ticks(2000);
        check("timeout err", 32'(err_cnt), 32'd4);
        send_byte(8'h44); send_byte(8'hAC);
        expect_quiet("timeout tail", 4);
        check("timeout tail err", 32'(err_cnt), 32'd4);
        ticks(2500);
        check("idle ticks err", 32'(err_cnt), 32'd4);
        send_frame(2, 1'b0);
        expect_packet("resent", 2, -1);
        check("resent err", 32'(err_cnt), 32'd4);

        // 16-word frame with a stray byte during replay
        for (int i = 0; i < 16; i++) payload[i] = 16'(16'hA000 + i * 16'h0111);
        send_frame(16, 1'b0);
        expect_packet("w16", 16, 3);
        check("w16 err", 32'(err_cnt), 32'd5);

        // reset at the second replay cycle
        for (int i = 0; i < 4; i++) payload[i] = 16'(16'h5A00 + i);
        send_frame(4, 1'b0);
        @(negedge clk_sys);
        check("rstplay w0 frm",  32'(pkg_frm),  32'd1);
        check("rstplay w0 data", 32'(pkg_data), 32'h5A00);
        rst_n = 1'b0;
        @(negedge clk_sys);
        check("rstplay frm",  32'(pkg_frm),  32'd0);
        check("rstplay vld",  32'(pkg_vld),  32'd0);
        check("rstplay data", 32'(pkg_data), 32'd0);
        check("rstplay err",  32'(err_cnt),  32'd0);
        rst_n = 1'b1;
        expect_quiet("rstplay", 20);

        // err_cnt saturation with LEN=00 frames
        for (int i = 0; i < 254; i++) begin
            send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        end
        check("sat 254", 32'(err_cnt), 32'hFE);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        check("sat 255", 32'(err_cnt), 32'hFF);
        for (int i = 0; i < 45; i++) begin
            send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        end
        check("sat 300", 32'(err_cnt), 32'hFF);

        // still delivers after saturation
        payload[0] = 16'hCAFE;
        send_frame(1, 1'b0);
        expect_packet("post sat", 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
